// File: rtl/xalu_muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives Start/MdOp/Cancel/A/B; the unit returns Busy, HI, LO and its FSM state.
interface xalu_muldiv_if;
  // Handshake: an operation is accepted at a rising edge where Start=1, Cancel=0,
  // Busy=0 and MdOp is 1..6. There is no ready signal; the hazard unit must not
  // present a new Start while Busy=1, and any such Start is dropped. Busy falling
  // marks the cycle in which a mult/div result is first visible on HI/LO.
  logic        Start;
  logic [2:0]  MdOp;
  logic        Cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  modport master (
    output Start, MdOp, Cancel, A, B,
    input  Busy, HI, LO, dbg_state
  );

  modport slave (
    input  Start, MdOp, Cancel, A, B,
    output Busy, HI, LO, dbg_state
  );
endinterface

// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched at accept; the result is written when the busy countdown expires.
module xalu_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  xalu_muldiv_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes and fixes signs afterwards; this also makes
  // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    dvd = (div_signed && a_q[31]) ? -a_q : a_q;
    dvs = (div_signed && b_q[31]) ? -b_q : b_q;
    if (dvs == 32'd0) dvs = 32'd1;
    uq  = dvd / dvs;
    ur  = dvd % dvs;
    quo = (div_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem = (div_signed && a_q[31]) ? -ur : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Cancel) begin
            case (bus.MdOp)
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q   <= bus.MdOp;
                a_q    <= bus.A;
                b_q    <= bus.B;
                cnt    <= (bus.MdOp == OP_MULT || bus.MdOp == OP_MULTU) ?
                          4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            busy_q <= 1'b0;
            state  <= IDLE;
            case (op_q)
              OP_MULT: begin
                hi_q <= prod_s[63:32];
                lo_q <= prod_s[31:0];
              end
              OP_MULTU: begin
                hi_q <= prod_u[63:32];
                lo_q <= prod_u[31:0];
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero burns the full busy period but leaves HI/LO alone.
                if (b_q != 32'd0) begin
                  hi_q <= rem;
                  lo_q <= quo;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Multi-cycle multiply/divide unit (XALU) in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI and LO architectural registers. Their values feed the ALU/HI/LO output-select mux in EX.
- Exposes Busy to the hazard unit, which stalls any later mult/div/mfhi/mflo/mthi/mtlo while Busy or Start is high.
- Start is suppressed when the exception/interrupt logic flushes the EX instruction.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, Busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  EX instruction is a mult/div/mthi/mtlo; qualified by MdOp
MdOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no effect)
Cancel  input  1  exception/interrupt taken this cycle; EX instruction must not modify HI/LO
A  input  32  forwarded rs value
B  input  32  forwarded rt value
Busy  output  1  operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; all state changes on the rising edge of clk.
- Reset: HI=0, LO=0, Busy=0, cycle counter=0, latched operands/op cleared.
- Reset has priority over everything. Reset mid-operation aborts the operation with no HI/LO write.
- Accept condition: Start=1, Cancel=0, Busy=0, MdOp in 1..6. Otherwise the inputs have no effect.
- Start while Busy=1 is ignored. The hazard unit guarantees it never occurs; the bench checks that HI/LO are unaffected.
- mthi/mtlo: at the accepting edge, HI<=A (mthi) or LO<=A (mtlo). Busy stays 0. The new value is visible the next cycle.
- mult/multu/div/divu, accepted at edge E0:
  - At E0, latch A, B and the op; counter<=N (MULT_CYCLES or DIV_CYCLES); Busy<=1.
  - Busy=1 for exactly N cycles after E0. The counter decrements each edge.
  - At the edge where the counter reaches 0, write HI/LO and set Busy<=0.
  - Result is visible N cycles after E0, in the same cycle Busy first reads 0.
  - HI/LO hold their old values while Busy=1.
- Only the operand values latched at E0 are used. Changes on A/B during Busy are ignored.
- State machine:
  - IDLE: Busy=0. Goes to RUN on an accepted mult/div.
  - RUN: Busy=1. Decrements the counter. On the last cycle, writes HI/LO and returns to IDLE.
  - Back-to-back accept is possible on the edge after returning to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 to 64-bit product.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Divide by zero (B=0, div or divu): the full DIV_CYCLES Busy period still runs; HI and LO remain unchanged.
- Cancel:
  - Cancel with Start in the same cycle means no accept, no Busy, no HI/LO change.
  - Cancel while Busy=1 does not abort, because the owning instruction has already committed past EX.
- Busy is a register output with no combinational path from the inputs.

Test Plan:
- Reset then idle: HI=0, LO=0, Busy=0. mthi A=0x12345678: the next cycle HI=0x12345678, Busy stays 0. mtlo A=0xDEADBEEF: LO=0xDEADBEEF.
- mult A=0xFFFFFFFE (-2), B=3: Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2: Busy=1 for exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2: LO=3, HI=1. div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero with HI=0x11, LO=0x22: Busy=1 for 10 cycles; afterwards HI=0x11, LO=0x22.
- Start and Cancel together with mult: Busy stays 0 and HI/LO are unchanged. Cancel asserted mid-mult: the result is still written at cycle 5.
- During Busy: a second Start with mtlo and A changes are ignored, and the original result is correct. Reset at cycle 3 of a div: Busy=0 and HI=LO=0 the next cycle, with no later write.
